gift_key_rewind: RTL and testbench

- Sequential GIFT-128 round-key generator for decryption. It sits beside the GIFT ISE datapath and feeds round keys in reverse order, from round ROUNDS-1 down to round 0.
- It accepts a 128-bit master key and fast-forwards the standard key update to the last round. It then emits each round key (U,V) through a valid/ready handshake, applying the inverse key update after every accepted key.

---
 rtl/gift_key_rewind_if.sv | 25 ++
 rtl/gift_key_rewind.sv | 141 ++++++++++++++
 tb/tb_gift_key_rewind.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/gift_key_rewind_if.sv
// Handshake bundle for gift_key_rewind: master-key intake, flush, round-key output.
// The master side offers keys and consumes round keys; the slave side is the generator.
interface gift_key_rewind_if;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         flush;
    logic         rk_valid;
    logic         rk_ready;
    logic [31:0]  rk_u;
    logic [31:0]  rk_v;
    logic [5:0]   rk_idx;
    logic         rk_last;
    logic         busy;

    modport master (
        output key_valid, key, flush, rk_ready,
        input  key_ready, rk_valid, rk_u, rk_v, rk_idx, rk_last, busy
    );

    modport slave (
        input  key_valid, key, flush, rk_ready,
        output key_ready, rk_valid, rk_u, rk_v, rk_idx, rk_last, busy
    );
endinterface

// File: rtl/gift_key_rewind.sv
// GIFT-128 decryption key generator: fast-forwards the key schedule, then rewinds it one round key at a time.
// Optional GIFT_KEY_FASTFWD_EN: FWD takes 4-round jumps while at least 4 rounds remain.
module gift_key_rewind #(
    parameter int ROUNDS = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    gift_key_rewind_if.slave  bus
);

    typedef logic [7:0][15:0] kw_t;
    typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

    localparam logic [5:0] LAST = 6'(ROUNDS - 1);

    function automatic logic [15:0] rotr2(input logic [15:0] w);
        return {w[1:0], w[15:2]};
    endfunction
    function automatic logic [15:0] rotr12(input logic [15:0] w);
        return {w[11:0], w[15:12]};
    endfunction
    function automatic logic [15:0] rotl2(input logic [15:0] w);
        return {w[13:0], w[15:14]};
    endfunction
    function automatic logic [15:0] rotl12(input logic [15:0] w);
        return {w[3:0], w[15:4]};
    endfunction

    function automatic kw_t fwd_step(input kw_t k);
        kw_t n;
        n[5:0] = k[7:2];
        n[7]   = rotr2(k[1]);
        n[6]   = rotr12(k[0]);
        return n;
    endfunction

    function automatic kw_t inv_step(input kw_t k);
        kw_t n;
        n[7:2] = k[5:0];
        n[1]   = rotl2(k[7]);
        n[0]   = rotl12(k[6]);
        return n;
    endfunction

`ifdef GIFT_KEY_FASTFWD_EN
    // Four forward steps bring every word back to its own slot, rotated once.
    function automatic kw_t fwd_jump(input kw_t k);
        kw_t n;
        for (int i = 0; i < 8; i++)
            n[i] = i[0] ? rotr2(k[i]) : rotr12(k[i]);
        return n;
    endfunction
`endif

    state_t     state_q, state_d;
    kw_t        key_q, key_d;
    logic [5:0] cnt_q, cnt_d;
    logic [5:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    key_d = bus.key;
                    cnt_d = LAST;
                    if (ROUNDS > 1) begin
                        state_d = FWD;
                    end else begin
                        state_d = EMIT;
                        idx_d   = '0;
                    end
                end
            end
            FWD: begin
`ifdef GIFT_KEY_FASTFWD_EN
                if (cnt_q >= 6'd4) begin
                    key_d = fwd_jump(key_q);
                    cnt_d = cnt_q - 6'd4;
                end else begin
                    key_d = fwd_step(key_q);
                    cnt_d = cnt_q - 6'd1;
                end
`else
                key_d = fwd_step(key_q);
                cnt_d = cnt_q - 6'd1;
`endif
                if (cnt_d == '0) begin
                    state_d = EMIT;
                    idx_d   = LAST;
                end
            end
            EMIT: begin
                if (bus.rk_ready) begin
                    if (idx_q != '0) begin
                        key_d = inv_step(key_q);
                        idx_d = idx_q - 6'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over any handshake completing in the same cycle.
        if (bus.flush) begin
            state_d = IDLE;
            key_d   = '0;
            cnt_d   = '0;
            idx_d   = '0;
        end
    end

    logic emit;
    assign emit          = (state_q == EMIT);
    assign bus.key_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rk_valid  = emit;
    assign bus.rk_u      = emit ? {key_q[5], key_q[4]} : 32'd0;
    assign bus.rk_v      = emit ? {key_q[1], key_q[0]} : 32'd0;
    assign bus.rk_idx    = idx_q;
    assign bus.rk_last   = emit && (idx_q == '0);

endmodule

// File: tb/tb_gift_key_rewind.sv
// Bench for gift_key_rewind: four instances (ROUNDS 2, 5, 40, 1) checked against a per-round key model.
module tb_gift_key_rewind;

    localparam int RT [4] = '{2, 5, 40, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         kv  [4];
    logic [127:0] kin [4];
    logic         fl  [4];
    logic         rr  [4];
    logic         kr  [4];
    logic         rv  [4];
    logic         rl  [4];
    logic         bz  [4];
    logic [31:0]  ru  [4];
    logic [31:0]  rvv [4];
    logic [5:0]   ri  [4];
    logic [127:0] kreg[4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        gift_key_rewind_if u_if ();
        gift_key_rewind #(.ROUNDS(RT[g])) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if)
        );
        assign u_if.key_valid = kv[g];
        assign u_if.key       = kin[g];
        assign u_if.flush     = fl[g];
        assign u_if.rk_ready  = rr[g];
        assign kr[g]   = u_if.key_ready;
        assign rv[g]   = u_if.rk_valid;
        assign rl[g]   = u_if.rk_last;
        assign bz[g]   = u_if.busy;
        assign ru[g]   = u_if.rk_u;
        assign rvv[g]  = u_if.rk_v;
        assign ri[g]   = u_if.rk_idx;
        assign kreg[g] = u_dut.key_q;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rot_r(input int x, input int n);
        return ((x >> n) | (x << (16 - n))) & 16'hffff;
    endfunction

    // Round r key = master key advanced r times by the standard schedule; returns {U,V}.
    function automatic logic [63:0] model_rk(input logic [127:0] mk, input int r);
        int w [8];
        int t7, t6;
        for (int i = 0; i < 8; i++) w[i] = int'(mk[16*i +: 16]);
        for (int s = 0; s < r; s++) begin
            t7 = rot_r(w[1], 2);
            t6 = rot_r(w[0], 12);
            for (int j = 0; j < 6; j++) w[j] = w[j+2];
            w[7] = t7;
            w[6] = t6;
        end
        return {w[5][15:0], w[4][15:0], w[1][15:0], w[0][15:0]};
    endfunction

    function automatic int exp_lat(input int r);
`ifdef GIFT_KEY_FASTFWD_EN
        return (r - 1) / 4 + (r - 1) % 4;
`else
        return r - 1;
`endif
    endfunction

    task automatic start_key(input int sel, input logic [127:0] mk);
        @(negedge clk);
        chk("key_ready_idle", 128'(kr[sel]), 128'd1);
        kv[sel] = 1'b1;
        kin[sel] = mk;
        @(negedge clk);
        kv[sel] = 1'b0;
    endtask

    task automatic wait_valid(input int sel, output int lat);
        lat = 0;
        while (!rv[sel] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!rv[sel]) chk("rk_valid_timeout", 128'(rv[sel]), 128'd1);
    endtask

    task automatic run_seq(input int sel, input logic [127:0] mk, input bit rnd_rdy,
                           input bit chk_first, input logic [31:0] fu, input logic [31:0] fv);
        int r, lat, e;
        logic [63:0] m;
        r = RT[sel];
        start_key(sel, mk);
        wait_valid(sel, lat);
        chk("fwd_latency", 128'(lat), 128'(exp_lat(r)));
        if (!rv[sel]) return;
        if (chk_first) begin
            chk("first_u", 128'(ru[sel]), 128'(fu));
            chk("first_v", 128'(rvv[sel]), 128'(fv));
        end
        e = r - 1;
        for (int guard = 0; e >= 0 && guard < 2000; guard++) begin
            m = model_rk(mk, e);
            chk("rk_valid", 128'(rv[sel]), 128'd1);
            chk("rk_idx", 128'(ri[sel]), 128'(e));
            chk("rk_u", 128'(ru[sel]), 128'(m[63:32]));
            chk("rk_v", 128'(rvv[sel]), 128'(m[31:0]));
            chk("rk_last", 128'(rl[sel]), 128'(e == 0));
            rr[sel] = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (rr[sel]) e--;
        end
        rr[sel] = 1'b0;
        chk("end_rk_valid", 128'(rv[sel]), 128'd0);
        chk("end_key_ready", 128'(kr[sel]), 128'd1);
        chk("end_busy", 128'(bz[sel]), 128'd0);
        chk("end_key_reg", kreg[sel], mk);
    endtask

    task automatic chk_idle(input int sel, input string tag);
        chk({tag, "_rk_valid"}, 128'(rv[sel]), 128'd0);
        chk({tag, "_key_ready"}, 128'(kr[sel]), 128'd1);
        chk({tag, "_busy"}, 128'(bz[sel]), 128'd0);
        chk({tag, "_rk_u"}, 128'(ru[sel]), 128'd0);
    endtask

    function automatic logic [127:0] rnd_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] TKEY = 128'h00112233_44556677_8899aabb_ccddeeff;

    initial begin
        int lat;
        for (int i = 0; i < 4; i++) begin
            kv[i] = 1'b0; kin[i] = '0; fl[i] = 1'b0; rr[i] = 1'b0;
        end
        #12;
        for (int i = 0; i < 4; i++) begin
            chk("rst_key_ready", 128'(kr[i]), 128'd1);
            chk("rst_rk_valid", 128'(rv[i]), 128'd0);
            chk("rst_rk_last", 128'(rl[i]), 128'd0);
            chk("rst_busy", 128'(bz[i]), 128'd0);
            chk("rst_rk_uv", {64'd0, ru[i], rvv[i]}, 128'd0);
            chk("rst_rk_idx", 128'(ri[i]), 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_seq(0, TKEY, 1'b0, 1'b1, 32'h00112233, 32'h8899aabb);
        run_seq(1, TKEY, 1'b0, 1'b1, 32'h51156776, 32'h7337effe);
        run_seq(1, rnd_key(), 1'b1, 1'b0, '0, '0);
        run_seq(3, TKEY, 1'b0, 1'b1, 32'h44556677, 32'hccddeeff);
        run_seq(3, rnd_key(), 1'b1, 1'b0, '0, '0);
        run_seq(2, rnd_key(), 1'b0, 1'b0, '0, '0);
        for (int n = 0; n < 3; n++) run_seq(2, rnd_key(), 1'b1, 1'b0, '0, '0);

        // flush while fast-forwarding; the simultaneous key offer must be dropped
        start_key(2, rnd_key());
        @(negedge clk);
        fl[2] = 1'b1; kv[2] = 1'b1;
        @(negedge clk);
        fl[2] = 1'b0; kv[2] = 1'b0;
        chk_idle(2, "flush_fwd");
        chk("flush_fwd_key_reg", kreg[2], 128'd0);

        // flush in IDLE beats a key offer
        @(negedge clk);
        fl[2] = 1'b1; kv[2] = 1'b1; kin[2] = rnd_key();
        @(negedge clk);
        fl[2] = 1'b0; kv[2] = 1'b0;
        chk_idle(2, "flush_idle");

        // flush together with rk_ready in EMIT
        start_key(2, rnd_key());
        wait_valid(2, lat);
        rr[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        fl[2] = 1'b1;
        @(negedge clk);
        fl[2] = 1'b0; rr[2] = 1'b0;
        chk_idle(2, "flush_emit");
        chk("flush_emit_rk_last", 128'(rl[2]), 128'd0);
        run_seq(2, rnd_key(), 1'b1, 1'b0, '0, '0);

        // asynchronous reset mid-EMIT
        start_key(2, rnd_key());
        wait_valid(2, lat);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_idle(2, "async_rst");
        chk("async_rst_rk_v", 128'(rvv[2]), 128'd0);
        chk("async_rst_rk_idx", 128'(ri[2]), 128'd0);
        chk("async_rst_rk_last", 128'(rl[2]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(2, rnd_key(), 1'b1, 1'b0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
